// File: rtl/note_pkg.sv
// Shared types and constants for the note sequencer: FSM states, melody
// entry layout and the default melody.
package note_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_PAUSE,
    S_END
  } state_t;

  // A duration of zero marks the end of the song.
  localparam int END_MARK = 0;

  localparam int NOTA_W = 3;

  // Stored melody layout: {tom, nota[2:0], dur[3:0]}.
  localparam int MEL_DUR_W    = 4;
  localparam int MEL_W        = MEL_DUR_W + NOTA_W + 1;
  localparam int MEL_DUR_LSB  = 0;
  localparam int MEL_NOTA_LSB = MEL_DUR_W;
  localparam int MEL_TOM_BIT  = MEL_DUR_W + NOTA_W;
  localparam int MEL_LEN      = 16;

  // Three notes and then the end marker. The remaining slots also hold the
  // marker, so any song length reads a terminated melody.
  localparam logic [MEL_W-1:0] DEFAULT_MELODY [MEL_LEN] = '{
    8'hA2, 8'h51, 8'hF3, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  // Field offsets inside the widened entry {tom, nota, dur[dur_w-1:0]}.
  function automatic int nota_lsb(int dur_w);
    return dur_w;
  endfunction

  function automatic int tom_bit(int dur_w);
    return dur_w + NOTA_W;
  endfunction

endpackage

// File: rtl/note_sequencer_rom.sv
// Melody ROM: combinational, case-based lookup returning the packed entry
// {tom, nota, dur} for the requested index. Swap this file to change melody.
module song_rom
  import note_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter int DUR_W    = 4,
  localparam int IDX_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1,
  localparam int EW      = DUR_W + NOTA_W + 1
) (
  input  logic [IDX_W-1:0] idx,
  output logic [EW-1:0]    entry
);

  logic [7:0]       addr;
  logic [MEL_W-1:0] raw;

  assign addr = 8'(idx);

  // Table lookup; anything past the song length reads as the end marker.
  always_comb begin
    raw = '0;
    case (addr)
      8'd0:    raw = DEFAULT_MELODY[0];
      8'd1:    raw = DEFAULT_MELODY[1];
      8'd2:    raw = DEFAULT_MELODY[2];
      8'd3:    raw = DEFAULT_MELODY[3];
      8'd4:    raw = DEFAULT_MELODY[4];
      8'd5:    raw = DEFAULT_MELODY[5];
      8'd6:    raw = DEFAULT_MELODY[6];
      8'd7:    raw = DEFAULT_MELODY[7];
      8'd8:    raw = DEFAULT_MELODY[8];
      8'd9:    raw = DEFAULT_MELODY[9];
      8'd10:   raw = DEFAULT_MELODY[10];
      8'd11:   raw = DEFAULT_MELODY[11];
      8'd12:   raw = DEFAULT_MELODY[12];
      8'd13:   raw = DEFAULT_MELODY[13];
      8'd14:   raw = DEFAULT_MELODY[14];
      8'd15:   raw = DEFAULT_MELODY[15];
      default: raw = '0;
    endcase
    if (int'(addr) >= SONG_LEN) raw = '0;
  end

  // Re-pack into the sequencer's duration width.
  assign entry = {raw[MEL_TOM_BIT],
                  raw[MEL_NOTA_LSB +: NOTA_W],
                  DUR_W'(raw[MEL_DUR_LSB +: MEL_DUR_W])};

endmodule

// File: rtl/note_sequencer.sv
// Melody player: steps through the song ROM, holds each note for its
// duration in prescaler ticks and presents tom/nota to the display decoder.
module note_sequencer
  import note_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int SONG_LEN = 16,
  parameter int DUR_W    = 4,
  localparam int IDX_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop_en,
  output logic             tom,
  output logic [2:0]       nota,
  output logic             note_valid,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] idx
);

  localparam int PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW       = DUR_W + NOTA_W + 1;
  localparam int NOTA_LSB = nota_lsb(DUR_W);
  localparam int TOM_BIT  = tom_bit(DUR_W);

  state_t           state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic [DUR_W-1:0] rem, rem_n;
  logic [IDX_W-1:0] idx_n;
  logic             tom_n;
  logic [2:0]       nota_n;

  logic [EW-1:0]    entry;
  logic [DUR_W-1:0] e_dur;
  logic [2:0]       e_nota;
  logic             e_tom;
  logic             tick;
  logic             last_entry;

  song_rom #(
    .SONG_LEN (SONG_LEN),
    .DUR_W    (DUR_W)
  ) u_rom (
    .idx   (idx),
    .entry (entry)
  );

  assign e_dur      = entry[DUR_W-1:0];
  assign e_nota     = entry[NOTA_LSB +: NOTA_W];
  assign e_tom      = entry[TOM_BIT];
  assign tick       = (presc == PW'(CLK_DIV - 1));
  assign last_entry = (idx == IDX_W'(SONG_LEN - 1));

  assign note_valid = (state == S_PLAY) || (state == S_PAUSE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_END) && !loop_en && !stop && !reset;

  // State, prescaler, note registers; everything returns to idle on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      presc <= '0;
      rem   <= '0;
      tom   <= 1'b0;
      nota  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      presc <= presc_n;
      rem   <= rem_n;
      tom   <= tom_n;
      nota  <= nota_n;
    end
  end

  // Next-state: stop overrides everything, pause freezes a sounding note,
  // start only matters when idle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    presc_n = presc;
    rem_n   = rem;
    tom_n   = tom;
    nota_n  = nota;

    if (stop) begin
      state_n = S_IDLE;
      idx_n   = '0;
      presc_n = '0;
      rem_n   = '0;
      tom_n   = 1'b0;
      nota_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state_n = S_LOAD;
        end

        S_LOAD: begin
          tom_n   = e_tom;
          nota_n  = e_nota;
          rem_n   = e_dur;
          presc_n = '0;
          state_n = (e_dur == DUR_W'(END_MARK)) ? S_END : S_PLAY;
        end

        // Leaving PAUSE counts as a normal play cycle, so every cycle with
        // pause high stretches the note by exactly one cycle.
        S_PLAY, S_PAUSE: begin
          if (pause) begin
            state_n = S_PAUSE;
          end else begin
            state_n = S_PLAY;
            if (tick) begin
              presc_n = '0;
              rem_n   = rem - 1'b1;
              if (rem == DUR_W'(1)) begin
                if (last_entry) begin
                  state_n = S_END;
                end else begin
                  idx_n   = idx + 1'b1;
                  state_n = S_LOAD;
                end
              end
            end else begin
              presc_n = presc + 1'b1;
            end
          end
        end

        S_END: begin
          idx_n = '0;
          if (loop_en) begin
            state_n = S_LOAD;
          end else begin
            state_n = S_IDLE;
            presc_n = '0;
            rem_n   = '0;
            tom_n   = 1'b0;
            nota_n  = '0;
          end
        end

        default: begin
          state_n = S_IDLE;
          idx_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with a short four-entry song: directed scenarios
// with literal timings plus a randomized run, all compared cycle by cycle
// against a behavioural model of the player.
module tb_note_sequencer;

  localparam int CLK_DIV  = 4;
  localparam int SONG_LEN = 4;
  localparam int DUR_W    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop_en = 1'b0;
  logic       tom;
  logic [2:0] nota;
  logic       note_valid;
  logic       busy;
  logic       done;
  logic [1:0] idx;

  note_sequencer #(
    .CLK_DIV  (CLK_DIV),
    .SONG_LEN (SONG_LEN),
    .DUR_W    (DUR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .tom        (tom),
    .nota       (nota),
    .note_valid (note_valid),
    .busy       (busy),
    .done       (done),
    .idx        (idx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // The song as a list of notes.
  int song_tom  [SONG_LEN] = '{1, 0, 1, 0};
  int song_nota [SONG_LEN] = '{2, 5, 7, 0};
  int song_dur  [SONG_LEN] = '{2, 1, 3, 0};

  // Player model: phase 0 idle, 1 articulation gap (fetch), 2 sounding,
  // 3 song end. A sounding note is just a count of cycles left.
  int m_phase = 0;
  int m_idx   = 0;
  int m_left  = 0;
  int m_tom   = 0;
  int m_nota  = 0;

  always @(posedge clk) begin
    if (reset || stop) begin
      m_phase = 0; m_idx = 0; m_left = 0; m_tom = 0; m_nota = 0;
    end else begin
      case (m_phase)
        0: if (start) m_phase = 1;
        1: begin
          m_tom  = song_tom[m_idx];
          m_nota = song_nota[m_idx];
          if (song_dur[m_idx] == 0) m_phase = 3;
          else begin
            m_left  = song_dur[m_idx] * CLK_DIV;
            m_phase = 2;
          end
        end
        2: if (!pause) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_idx == SONG_LEN - 1) m_phase = 3;
            else begin
              m_idx   = m_idx + 1;
              m_phase = 1;
            end
          end
        end
        default: begin
          m_idx = 0;
          if (loop_en) m_phase = 1;
          else begin
            m_phase = 0; m_left = 0; m_tom = 0; m_nota = 0;
          end
        end
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare all outputs with the model; packed as {tom,nota,nv,busy,done,idx}.
  task automatic cycle_compare();
    int act;
    int exp_v;
    bit exp_done;
    exp_done = (m_phase == 3) && !loop_en && !stop && !reset;
    act   = int'({tom, nota, note_valid, busy, done, idx});
    exp_v = m_tom * 256 + m_nota * 32 + ((m_phase == 2) ? 16 : 0)
          + ((m_phase != 0) ? 8 : 0) + (exp_done ? 4 : 0) + m_idx;
    check($sformatf("cycle@%0t", $time), act, exp_v);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (cmp_en) cycle_compare();
  endtask

  // Measure how long the current note sounds. Optionally holds pause for
  // valid cycles [p_from, p_to) and re-pulses start on valid cycle rs_at.
  task automatic measure(input string name, input int e_tom, input int e_nota,
                         input int e_len, input int p_from, input int p_to,
                         input int rs_at);
    int n;
    n = 0;
    check({name, " valid"}, int'(note_valid), 1);
    check({name, " tom"}, int'(tom), e_tom);
    while (note_valid && (int'(nota) == e_nota) && n < 200) begin
      n++;
      pause = (n >= p_from) && (n < p_to);
      start = (n == rs_at);
      step();
    end
    pause = 1'b0;
    start = 1'b0;
    check({name, " length"}, n, e_len);
    check({name, " gap valid"}, int'(note_valid), 0);
  endtask

  task automatic check_idle(input string name);
    check({name, " busy"}, int'(busy), 0);
    check({name, " valid"}, int'(note_valid), 0);
    check({name, " done"}, int'(done), 0);
    check({name, " tom"}, int'(tom), 0);
    check({name, " nota"}, int'(nota), 0);
    check({name, " idx"}, int'(idx), 0);
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  initial begin
    step();
    cmp_en = 1'b1;
    step();
    reset = 1'b0;
    check_idle("reset");

    // Full song, no loop.
    start = 1'b1;
    step();
    start = 1'b0;
    check("s1 load busy", int'(busy), 1);
    check("s1 load valid", int'(note_valid), 0);
    step();
    check("s1 first nota", int'(nota), 2);
    measure("s1 n0", 1, 2, 8, 0, 0, 0);
    step();
    measure("s1 n1", 0, 5, 4, 0, 0, 0);
    step();
    measure("s1 n2", 1, 7, 12, 0, 0, 0);
    check("s1 marker idx", int'(idx), 3);
    check("s1 marker nota held", int'(nota), 7);
    step();
    check("s1 end done", int'(done), 1);
    check("s1 end busy", int'(busy), 1);
    step();
    check_idle("s1 after end");

    // Looping song.
    loop_en = 1'b1;
    kick();
    measure("s2 n0", 1, 2, 8, 0, 0, 0);
    step();
    measure("s2 n1", 0, 5, 4, 0, 0, 0);
    step();
    measure("s2 n2", 1, 7, 12, 0, 0, 0);
    step();
    check("s2 end no done", int'(done), 0);
    check("s2 end busy", int'(busy), 1);
    step();
    check("s2 reload idx", int'(idx), 0);
    check("s2 reload busy", int'(busy), 1);
    step();
    measure("s2 n0 again", 1, 2, 8, 0, 0, 0);
    loop_en = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("s2 stop");

    // Pause five cycles inside note 0.
    kick();
    measure("s3 paused n0", 1, 2, 13, 3, 8, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Stop during note 1, then replay from entry 0.
    kick();
    measure("s4 n0", 1, 2, 8, 0, 0, 0);
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("s4 stop");
    kick();
    check("s4 replay nota", int'(nota), 2);
    check("s4 replay valid", int'(note_valid), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // start with stop in idle; start re-pulsed mid-note.
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("s5 start+stop busy", int'(busy), 0);
    kick();
    measure("s5 restart n0", 1, 2, 8, 0, 0, 4);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Reset mid-note; prescaler restarts on the next start.
    kick();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("s6 reset");
    kick();
    measure("s6 n0", 1, 2, 8, 0, 0, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Randomized controls, checked every cycle against the model.
    repeat (4000) begin
      reset = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      pause = ($urandom_range(0, 5) == 0);
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      step();
    end
    reset = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a fixed melody stored in an on-chip ROM, stepping through entries of {tom, nota, duration} and presenting the current note to the 7-segment note display and the tone generator. Sits between the user controls (start/stop/pause/loop) and the `display7seg` decoder. It owns all timing: a clock prescaler produces duration ticks, and a small FSM sequences the ROM. Outputs `tom`/`nota` connect directly to the display decoder inputs of the same names.

## Interface
- `CLK_DIV`, default 50000: clock cycles per duration tick (≥2).
- `SONG_LEN`, default 16: number of ROM entries (≤256).
- `DUR_W`, default 4: width of the per-note duration field, in ticks.
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; begins playback from entry 0 when in IDLE.
- `stop`  in  1  level; aborts playback and returns to IDLE.
- `pause`  in  1  level; freezes playback while high.
- `loop_en`  in  1  sampled at end of song; 1 = restart from entry 0.
- `tom`  out  1  current note's tone flag, to display/tone generator.
- `nota`  out  3  current note code, 0–7.
- `note_valid`  out  1  1 while a note is sounding (PLAY or PAUSE).
- `busy`  out  1  1 in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a non-looping song ends.
- `idx`  out  $clog2(SONG_LEN)  index of the current ROM entry.

## Operation
- ROM entry: 8+ bits, {tom, nota[2:0], dur[DUR_W-1:0]}. Combinational read at `idx`.
- `dur == 0` is the end-of-song marker. Reaching `idx == SONG_LEN-1` after playing it also ends the song.
- States:
  - IDLE: outputs low, `idx = 0`. `start` → LOAD.
  - LOAD: latch entry[idx] into the `tom`/`nota`/remaining registers. If `dur == 0`, go to END; otherwise go to PLAY with the prescaler cleared.
  - PLAY: the prescaler counts 0..CLK_DIV-1. On wrap (tick), remaining decrements. When remaining reaches 0 on a tick: if `idx == SONG_LEN-1`, go to END; otherwise `idx++` and go to LOAD.
  - PAUSE: prescaler and remaining frozen, `note_valid` held at 1. `pause` low → PLAY.
  - END: if `loop_en`, set `idx = 0` and go to LOAD. Otherwise pulse `done`, then IDLE.
- Priority in every state: `reset` > `stop` > `pause` > `start`. `stop` forces IDLE next cycle with `done` = 0.
- `start` while `busy` is ignored. `pause` in IDLE, LOAD or END has no effect.
- `note_valid` is 0 in LOAD and END. This gives a one-cycle articulation gap between notes.
- `tom`/`nota` keep their last values during LOAD/END and clear to 0 in IDLE.

## Timing
- Reset values: state IDLE, `idx` 0, prescaler 0, remaining 0, `tom` 0, `nota` 0, `note_valid` 0, `busy` 0, `done` 0.
- `start` sampled high at cycle N: `busy` = 1 at N+1 (LOAD); `note_valid` = 1 with entry 0 at N+2.
- A note with duration d is valid for exactly d·CLK_DIV cycles, followed by 1 cycle of LOAD.
- Each pause cycle extends the note by exactly one cycle. Pause and tick in the same cycle: pause wins and the tick is not consumed.
- `done` is high for exactly one cycle (END), and `busy` is still 1 in that cycle.
- `stop` on the same cycle as a tick: the tick is discarded.

## Structure
- Shared package `note_pkg` holds:
  - the state enum;
  - the entry field offsets;
  - localparam `END_MARK = 0`;
  - the default melody constant.
- Sub-module `song_rom`: a combinational case-based ROM over `idx` returning the packed entry. It is parameterized by `SONG_LEN` and is replaceable per melody.
- The prescaler lives inline in the top level.

## Test plan
All scenarios use `CLK_DIV=4`, `SONG_LEN=4`, and ROM = {1,3'd2,dur 2}, {0,3'd5,dur 1}, {1,3'd7,dur 3}, {0,0,dur 0}.
- Reset, then `start` pulse at cycle 0:
  - `note_valid` rises at cycle 2 with `tom`=1, `nota`=2, held for 8 cycles;
  - gap of 1 cycle, then `nota`=5 for 4 cycles, then `nota`=7 for 12 cycles;
  - END reached at the marker: `done` pulses once, `busy` falls the next cycle.
- Same song with `loop_en`=1: after the `nota`=7 note, LOAD of `idx` 0 follows END with no `done` pulse; `nota`=2 reappears.
- `pause` high for 5 cycles in the middle of note 0: note 0 lasts 13 cycles, and `note_valid` stays 1 throughout.
- `stop` asserted during note 1: the next cycle shows IDLE, all outputs 0, `idx`=0, `done`=0. A subsequent `start` replays from entry 0.
- Simultaneous events:
  - `start` and `stop` together in IDLE: remains IDLE;
  - `start` re-pulsed during PLAY: timing is unchanged.
- `reset` asserted mid-note: outputs take their reset values the next cycle; the prescaler restarts from 0 on the next `start`.
